// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single off-chip memory port between the
// read-only I-cache and the read/write D-cache.
//
// Each grant runs IDLE -> BUSY_I/BUSY_D -> RELEASE -> IDLE.
// Every output is a register.
//
// Optional macro ARB_RR_EN: when defined, simultaneous requests are
// arbitrated round-robin, so the requester that did not receive the
// previous grant wins. When the macro is undefined, the D-cache always
// has priority over the I-cache.
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state;
  logic   d_req;
  logic   grant_d;

`ifdef ARB_RR_EN
  // Set when the most recent grant went to the D-cache.
  logic   last_d;
`endif

  // Arbitration decision for the IDLE state.
  always_comb begin
    d_req = d_read | d_write;
`ifdef ARB_RR_EN
    grant_d = d_req & (~i_read | ~last_d);
`else
    grant_d = d_req;
`endif
  end

  // Grant/transaction FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_RR_EN
      last_d    <= 1'b1;
`endif
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            // If d_read and d_write are both high, the write wins.
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_write <= d_write;
            mem_read  <= ~d_write;
            state     <= BUSY_D;
`ifdef ARB_RR_EN
            last_d    <= 1'b1;
`endif
          end else if (i_read) begin
            mem_addr  <= i_addr;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            state     <= BUSY_I;
`ifdef ARB_RR_EN
            last_d    <= 1'b0;
`endif
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_read <= 1'b0;
            i_rdata  <= mem_rdata;
            i_ready  <= 1'b1;
            state    <= RELEASE;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            // A write completion leaves d_rdata unchanged.
            if (mem_read) d_rdata <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            d_ready   <= 1'b1;
            state     <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Expectations follow ARB_RR_EN in the same way as the design build.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  int vectors;
  int miscompares;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL reset mem_read: got %b want 0", mem_read); end
    vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL reset mem_write: got %b want 0", mem_write); end
    vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
    vectors++; if (mem_wdata !== '0) begin miscompares++; $display("FAIL reset mem_wdata: got %h want 0", mem_wdata); end
    vectors++; if (i_ready !== 1'b0 || d_ready !== 1'b0) begin miscompares++; $display("FAIL reset ready: got i=%b d=%b want 0", i_ready, d_ready); end
    vectors++; if (i_rdata !== '0 || d_rdata !== '0) begin miscompares++; $display("FAIL reset rdata: got i=%h d=%h want 0", i_rdata, d_rdata); end
    rst = 1'b0;
    tick();
    vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL idle mem_read: got %b want 0", mem_read); end
  endtask

  task automatic test_i_read;
    i_read = 1'b1; i_addr = 28'h0000010;
    tick();
    vectors++; if (mem_addr !== 28'h10) begin miscompares++; $display("FAIL i_read mem_addr: got %h want 10", mem_addr); end
    vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL i_read mem_write: got %b want 0", mem_write); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (mem_read !== 1'b1) begin miscompares++; $display("FAIL i_read mem_read cycle %0d: got %b want 1", k, mem_read); end
      vectors++; if (i_ready !== 1'b0) begin miscompares++; $display("FAIL i_read early i_ready cycle %0d: got %b want 0", k, i_ready); end
      if (k < 3) tick();
    end
    mem_ready = 1'b1; mem_rdata = 128'hA5;
    tick();
    mem_ready = 1'b0; i_read = 1'b0;
    vectors++; if (i_ready !== 1'b1) begin miscompares++; $display("FAIL i_read i_ready: got %b want 1", i_ready); end
    vectors++; if (i_rdata !== 128'hA5) begin miscompares++; $display("FAIL i_read i_rdata: got %h want a5", i_rdata); end
    vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL i_read mem_read drop: got %b want 0", mem_read); end
    vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL i_read d_ready: got %b want 0", d_ready); end
    tick();
    vectors++; if (i_ready !== 1'b0) begin miscompares++; $display("FAIL i_read pulse width: got %b want 0", i_ready); end
  endtask

  task automatic test_d_write;
    d_write = 1'b1; d_addr = 28'h20; d_wdata = 128'h1234;
    tick();
    vectors++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin miscompares++; $display("FAIL d_write cmd: got w=%b r=%b want w=1 r=0", mem_write, mem_read); end
    vectors++; if (mem_addr !== 28'h20) begin miscompares++; $display("FAIL d_write mem_addr: got %h want 20", mem_addr); end
    vectors++; if (mem_wdata !== 128'h1234) begin miscompares++; $display("FAIL d_write mem_wdata: got %h want 1234", mem_wdata); end
    // Drop the request and disturb the inputs mid-transaction.
    d_write = 1'b0; d_addr = 28'h21; d_wdata = 128'hFFFF;
    tick();
    vectors++; if (mem_write !== 1'b1) begin miscompares++; $display("FAIL d_write hold: got %b want 1", mem_write); end
    vectors++; if (mem_addr !== 28'h20 || mem_wdata !== 128'h1234) begin miscompares++; $display("FAIL d_write latched: got %h/%h want 20/1234", mem_addr, mem_wdata); end
    mem_ready = 1'b1; mem_rdata = 128'hCAFE;
    tick();
    mem_ready = 1'b0;
    vectors++; if (d_ready !== 1'b1) begin miscompares++; $display("FAIL d_write d_ready: got %b want 1", d_ready); end
    vectors++; if (d_rdata !== '0) begin miscompares++; $display("FAIL d_write d_rdata: got %h want 0", d_rdata); end
    vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL d_write drop: got %b want 0", mem_write); end
    tick();
    vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL d_write pulse width: got %b want 0", d_ready); end
  endtask

  task automatic test_simultaneous;
    logic first_is_i;
`ifdef ARB_RR_EN
    first_is_i = 1'b1;
`else
    first_is_i = 1'b0;
`endif
    i_read = 1'b1; i_addr = 28'h40;
    d_read = 1'b1; d_addr = 28'h50;
    tick();
    vectors++; if (mem_read !== 1'b1 || mem_addr !== (first_is_i ? 28'h40 : 28'h50)) begin miscompares++; $display("FAIL simul first grant: got r=%b a=%h want first_is_i=%b", mem_read, mem_addr, first_is_i); end
    mem_ready = 1'b1; mem_rdata = 128'h111;
    tick();
    mem_ready = 1'b0;
    vectors++; if (i_ready !== first_is_i || d_ready !== ~first_is_i) begin miscompares++; $display("FAIL simul first ready: got i=%b d=%b want i=%b", i_ready, d_ready, first_is_i); end
    vectors++; if ((first_is_i ? i_rdata : d_rdata) !== 128'h111) begin miscompares++; $display("FAIL simul first rdata: got i=%h d=%h want 111", i_rdata, d_rdata); end
    if (first_is_i) i_read = 1'b0; else d_read = 1'b0;
    tick();
    vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL simul release gap: got %b want 0", mem_read); end
    tick();
    vectors++; if (mem_read !== 1'b1 || mem_addr !== (first_is_i ? 28'h50 : 28'h40)) begin miscompares++; $display("FAIL simul second grant: got r=%b a=%h", mem_read, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 128'h222;
    tick();
    mem_ready = 1'b0; i_read = 1'b0; d_read = 1'b0;
    vectors++; if (i_ready !== ~first_is_i || d_ready !== first_is_i) begin miscompares++; $display("FAIL simul second ready: got i=%b d=%b", i_ready, d_ready); end
    vectors++; if ((first_is_i ? d_rdata : i_rdata) !== 128'h222) begin miscompares++; $display("FAIL simul second rdata: got i=%h d=%h want 222", i_rdata, d_rdata); end
    tick();
  endtask

  task automatic test_stale_request;
    i_read = 1'b1; i_addr = 28'h60;
    tick();
    mem_ready = 1'b1; mem_rdata = 128'h333;
    tick();
    mem_ready = 1'b0;
    vectors++; if (i_ready !== 1'b1) begin miscompares++; $display("FAIL stale i_ready: got %b want 1", i_ready); end
    tick();
    vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL stale release mem_read: got %b want 0", mem_read); end
    i_read = 1'b0;
    tick();
    vectors++; if (mem_read !== 1'b0 || i_ready !== 1'b0) begin miscompares++; $display("FAIL stale idle: got r=%b rdy=%b want 0", mem_read, i_ready); end
  endtask

  task automatic test_spurious_ready;
    mem_ready = 1'b1; mem_rdata = 128'hDEAD;
    tick();
    mem_ready = 1'b0;
    vectors++; if (i_ready !== 1'b0 || d_ready !== 1'b0) begin miscompares++; $display("FAIL spurious ready: got i=%b d=%b want 0", i_ready, d_ready); end
    vectors++; if (i_rdata !== 128'h333) begin miscompares++; $display("FAIL spurious i_rdata hold: got %h want 333", i_rdata); end
  endtask

  task automatic test_reset_mid;
    d_read = 1'b1; d_addr = 28'h70;
    tick();
    vectors++; if (mem_read !== 1'b1) begin miscompares++; $display("FAIL rstmid grant: got %b want 1", mem_read); end
    tick();
    tick();
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 128'h444;
    tick();
    vectors++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0) begin miscompares++; $display("FAIL rstmid cmds: got r=%b w=%b a=%h want 0", mem_read, mem_write, mem_addr); end
    vectors++; if (d_ready !== 1'b0 || d_rdata !== '0 || i_rdata !== '0) begin miscompares++; $display("FAIL rstmid outputs: got rdy=%b d=%h i=%h want 0", d_ready, d_rdata, i_rdata); end
    rst = 1'b0; mem_ready = 1'b0; d_read = 1'b0;
    tick();
    vectors++; if (d_ready !== 1'b0 || mem_read !== 1'b0) begin miscompares++; $display("FAIL rstmid after: got rdy=%b r=%b want 0", d_ready, mem_read); end
    i_read = 1'b1; i_addr = 28'h80;
    tick();
    vectors++; if (mem_read !== 1'b1 || mem_addr !== 28'h80) begin miscompares++; $display("FAIL rstmid new grant: got r=%b a=%h want 1/80", mem_read, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 128'hBEEF;
    tick();
    mem_ready = 1'b0; i_read = 1'b0;
    vectors++; if (i_ready !== 1'b1 || i_rdata !== 128'hBEEF) begin miscompares++; $display("FAIL rstmid new done: got rdy=%b data=%h want 1/beef", i_ready, i_rdata); end
    tick();
  endtask

  task automatic test_read_write_both;
    d_read = 1'b1; d_write = 1'b1; d_addr = 28'h30; d_wdata = 128'h5555;
    tick();
    vectors++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin miscompares++; $display("FAIL rw cmd: got w=%b r=%b want w=1 r=0", mem_write, mem_read); end
    vectors++; if (mem_addr !== 28'h30 || mem_wdata !== 128'h5555) begin miscompares++; $display("FAIL rw addr/data: got %h/%h want 30/5555", mem_addr, mem_wdata); end
    tick();
    vectors++; if (mem_read !== 1'b0 || mem_write !== 1'b1) begin miscompares++; $display("FAIL rw hold: got r=%b w=%b want r=0 w=1", mem_read, mem_write); end
    mem_ready = 1'b1; mem_rdata = 128'h666;
    tick();
    mem_ready = 1'b0; d_read = 1'b0; d_write = 1'b0;
    vectors++; if (d_ready !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin miscompares++; $display("FAIL rw done: got rdy=%b r=%b w=%b want 1/0/0", d_ready, mem_read, mem_write); end
    vectors++; if (d_rdata !== '0) begin miscompares++; $display("FAIL rw d_rdata: got %h want 0", d_rdata); end
    tick();
    vectors++; if (d_ready !== 1'b0 || mem_read !== 1'b0) begin miscompares++; $display("FAIL rw after: got rdy=%b r=%b want 0", d_ready, mem_read); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_i_read();
    test_d_write();
    test_simultaneous();
    test_stale_request();
    test_spurious_ready();
    test_reset_mid();
    test_read_write_both();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
